cpu_nios_switch_ctrl: RTL and testbench

Debounced, interrupt-capable input controller for the alarm-clock board switches, sitting between the raw `in_port` pins and the Nios II data master as an Avalon-MM slave. It synchronizes each switch, filters contact bounce with a per-bit stability counter, and latches debounced edges into a capture register. A maskable level interrupt lets firmware react to switch changes (set-time, alarm-enable) without polling.

---
 rtl/cpu_nios_switch_pkg.sv | 14 +
 rtl/cpu_nios_switch_debounce.sv | 60 ++++++
 rtl/cpu_nios_switch_ctrl.sv | 72 +++++++
 tb/tb_cpu_nios_switch_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_nios_switch_pkg.sv
// rtl/cpu_nios_switch_pkg.sv - register map and debounce state type for the switch controller
package cpu_nios_switch_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic {
    DEB_STABLE   = 1'b0,
    DEB_COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/cpu_nios_switch_debounce.sv
// rtl/cpu_nios_switch_debounce.sv - one-bit synchronizer plus stability-counter debouncer
module cpu_nios_switch_debounce
  import cpu_nios_switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic sync,
  output logic deb,
  output logic chg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          deb_next;
  deb_state_e    state;

  // The state is fully determined by whether the synchronized pin disagrees with deb.
  assign state = (sync != deb) ? DEB_COUNTING : DEB_STABLE;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      deb  <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= pin;
      sync <= meta;
      deb  <= deb_next;
      cnt  <= cnt_next;
    end
  end

  always_comb begin
    cnt_next = cnt;
    deb_next = deb;
    chg      = 1'b0;
    case (state)
      DEB_STABLE: cnt_next = '0;
      DEB_COUNTING: begin
        if (cnt == LAST) begin
          deb_next = sync;
          cnt_next = '0;
          chg      = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: cnt_next = '0;
    endcase
  end

endmodule

// File: rtl/cpu_nios_switch_ctrl.sv
// rtl/cpu_nios_switch_ctrl.sv - Avalon-MM debounced switch input port with edge capture and irq
module cpu_nios_switch_ctrl
  import cpu_nios_switch_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_vec;
  logic [WIDTH-1:0] deb_vec;
  logic [WIDTH-1:0] chg_vec;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cpu_nios_switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[i]),
      .sync   (sync_vec[i]),
      .deb    (deb_vec[i]),
      .chg    (chg_vec[i])
    );
  end

  assign wr       = chipselect & ~write_n;
  assign edge_clr = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = deb_vec;
      ADDR_RAW:  rd_mux[WIDTH-1:0] = sync_vec;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
      default:   rd_mux = '0;
    endcase
  end

  // Capture is OR'd in after the clear so a coincident debounced edge is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_cap <= (edge_cap & ~edge_clr) | chg_vec;
      irq      <= |(edge_cap & irq_mask);
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_cpu_nios_switch_ctrl.sv
// tb/tb_cpu_nios_switch_ctrl.sv - directed vector bench for cpu_nios_switch_ctrl
module tb_cpu_nios_switch_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int vectors = 0;
  int misses  = 0;

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  cpu_nios_switch_ctrl #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic wr_drive(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
  endtask

  initial begin
    logic bounce_bad;
    logic irq_seen;

    // addr, cs, wn, wdata, expected readdata (pre-edge contents of addr), expected irq
    vecs[0]  = '{2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
    vecs[1]  = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[2]  = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h3, 1'b0};
    vecs[3]  = '{2'd0, 1'b1, 1'b0, 32'hFF,       32'h0, 1'b0};
    vecs[4]  = '{2'd0, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
    vecs[5]  = '{2'd1, 1'b1, 1'b0, 32'hFF,       32'h0, 1'b0};
    vecs[6]  = '{2'd1, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
    vecs[7]  = '{2'd2, 1'b0, 1'b0, 32'h0,        32'h3, 1'b0};
    vecs[8]  = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h3, 1'b0};
    vecs[9]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h3, 1'b0};
    vecs[10] = '{2'd2, 1'b1, 1'b0, 32'h1,        32'h3, 1'b0};
    vecs[11] = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h1, 1'b0};
    vecs[12] = '{2'd3, 1'b1, 1'b0, 32'h3,        32'h0, 1'b0};
    vecs[13] = '{2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
    vecs[14] = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h1, 1'b0};
    vecs[15] = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};

    reset_n = 1'b0;
    address = 2'd0;
    in_port = 2'b00;
    idle();
    repeat (3) tick();
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      address    = vecs[i].addr;
      chipselect = vecs[i].cs;
      write_n    = vecs[i].wn;
      writedata  = vecs[i].wdata;
      tick();
      chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end
    idle();

    // Clean press on bit 0: sync after 2 edges, deb after 10, readdata one edge later.
    address = 2'd1;
    in_port = 2'b01;
    tick(); tick();
    chk("press_raw_e2", readdata, 32'h0);
    tick();
    chk("press_raw_e3", readdata, 32'h1);
    address = 2'd0;
    repeat (7) tick();
    chk("press_data_e10", readdata, 32'h0);
    tick();
    chk("press_data_e11", readdata, 32'h1);
    address = 2'd3;
    tick();
    chk("press_edge", readdata, 32'h1);
    chk("press_irq_masked", 32'(irq), 32'h0);
    wr_drive(2'd3, 32'h1);
    tick();
    idle();
    tick();
    chk("press_edge_cleared", readdata, 32'h0);

    // Bounce on bit 1: never stable long enough to be accepted.
    address = 2'd0;
    bounce_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) in_port[1] = ~in_port[1];
      tick();
      if (readdata[1]) bounce_bad = 1'b1;
    end
    in_port[1] = 1'b0;
    repeat (15) begin
      tick();
      if (readdata[1]) bounce_bad = 1'b1;
    end
    chk("bounce_data_seen", 32'(bounce_bad), 32'h0);
    chk("bounce_data", readdata, 32'h1);
    address = 2'd3;
    tick();
    chk("bounce_edge", readdata, 32'h0);

    // Masked release: edge captured, irq quiet until the mask is opened.
    in_port  = 2'b00;
    irq_seen = 1'b0;
    repeat (11) begin
      tick();
      if (irq) irq_seen = 1'b1;
    end
    chk("masked_edge", readdata, 32'h1);
    chk("masked_irq_quiet", 32'(irq_seen), 32'h0);
    wr_drive(2'd2, 32'h1);
    tick();
    idle();
    chk("mask_write_irq_w", 32'(irq), 32'h0);
    tick();
    chk("mask_write_irq_w1", 32'(irq), 32'h1);
    address = 2'd3;
    wr_drive(2'd3, 32'h1);
    tick();
    idle();
    chk("clear_irq_c", 32'(irq), 32'h1);
    tick();
    chk("clear_irq_c1", 32'(irq), 32'h0);

    // Interrupt path: edge capture at edge 10, irq at edge 11.
    address = 2'd3;
    in_port = 2'b01;
    repeat (9) tick();
    chk("ipath_irq_e9", 32'(irq), 32'h0);
    tick();
    chk("ipath_irq_e10", 32'(irq), 32'h0);
    chk("ipath_edge_e10", readdata, 32'h0);
    tick();
    chk("ipath_irq_e11", 32'(irq), 32'h1);
    chk("ipath_edge_e11", readdata, 32'h1);
    wr_drive(2'd3, 32'h1);
    tick();
    idle();
    chk("ipath_clr_c", 32'(irq), 32'h1);
    tick();
    chk("ipath_clr_c1", 32'(irq), 32'h0);

    // Clearing write on the same edge as chg: capture wins.
    address = 2'd3;
    in_port = 2'b00;
    repeat (9) tick();
    wr_drive(2'd3, 32'h1);
    tick();
    idle();
    chk("collide_e10", readdata, 32'h0);
    tick();
    chk("collide_e11", readdata, 32'h1);
    chk("collide_irq", 32'(irq), 32'h1);
    tick();
    chk("collide_hold", readdata, 32'h1);

    // Reset with the counter at 5 and the pin held high.
    address = 2'd0;
    in_port = 2'b01;
    repeat (7) tick();
    reset_n = 1'b0;
    tick(); tick();
    chk("midrst_rd", readdata, 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    address = 2'd2;
    tick();
    chk("midrst_mask", readdata, 32'h0);
    address = 2'd3;
    tick();
    chk("midrst_edge", readdata, 32'h0);
    address = 2'd0;
    repeat (8) tick();
    chk("midrst_data_r10", readdata, 32'h0);
    tick();
    chk("midrst_data_r11", readdata, 32'h1);
    address = 2'd3;
    tick();
    chk("midrst_edge_after", readdata, 32'h1);
    chk("midrst_irq_after", 32'(irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
